serial_mag_compare: RTL and testbench

Bit-serial magnitude comparator that consumes the per-bit greater/equal/less flags produced by the 1-bit comparator stage, MSB first, one bit per accepted cycle. After WIDTH accepted bits it issues a single registered verdict (A>B, A==B, A<B) for the full WIDTH-bit operands. It sits directly downstream of the 1-bit comparator and lets the design compare wide words with a single bit-slice.

---
 rtl/serial_mag_compare.sv | 173 +++++++++++++++++
 tb/tb_serial_mag_compare.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare.sv
// ----------------------------------------------------------------------------
// serial_mag_compare
//
// Bit-serial magnitude comparator. It consumes the greater/equal/less flag
// triple from a 1-bit comparator slice, MSB first, one bit per cycle in which
// bit_valid is high. After WIDTH consumed bits it registers one verdict for
// the full WIDTH-bit operands. The first bit position that differs decides
// the result, and later bits cannot change it.
//
// Parameters
//   WIDTH     operand width in bits (2..64)
//   CNT_W     bit-counter width, derived from WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new comparison (sampled only in IDLE / DONE)
//   bit_valid  gt_bit/eq_bit/lt_bit are valid and consumed this cycle
//   gt_bit     slice flag: A bit > B bit
//   eq_bit     slice flag: A bit == B bit
//   lt_bit     slice flag: A bit < B bit
//   busy       high while a comparison is running
//   done       one-cycle pulse when the verdict becomes valid
//   a_gt_b     verdict A > B
//   a_eq_b     verdict A == B
//   a_lt_b     verdict A < B
//   err        sticky: a non-one-hot flag triple was seen in this comparison
// ----------------------------------------------------------------------------
module serial_mag_compare #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_valid,
   input  logic gt_bit,
   input  logic eq_bit,
   input  logic lt_bit,
   output logic busy,
   output logic done,
   output logic a_gt_b,
   output logic a_eq_b,
   output logic a_lt_b,
   output logic err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Index of the final bit; reaching it while consuming ends the comparison,
   // so the counter never wraps.
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             decided_q, decided_d;  // a differing bit has been seen
   logic             dec_gt_q,  dec_gt_d;   // direction of that first difference
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             gt_q,      gt_d;
   logic             eq_q,      eq_d;
   logic             lt_q,      lt_d;
   logic             err_q,     err_d;

   logic             onehot;

   // Exactly one of the three slice flags must be set. Anything else is
   // flagged and the bit is treated as equal, so it never decides.
   always_comb begin
      onehot = ({gt_bit, eq_bit, lt_bit} == 3'b100) ||
               ({gt_bit, eq_bit, lt_bit} == 3'b010) ||
               ({gt_bit, eq_bit, lt_bit} == 3'b001);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      dec_gt_d  = dec_gt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;        // done is a single-cycle pulse
      gt_d      = gt_q;
      eq_d      = eq_q;
      lt_d      = lt_q;
      err_d     = err_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            // bit_valid is ignored here, even in the same cycle as start.
            if (start) begin
               state_d   = S_RUN;
               cnt_d     = '0;
               decided_d = 1'b0;
               dec_gt_d  = 1'b0;
               busy_d    = 1'b1;
               gt_d      = 1'b0;
               eq_d      = 1'b0;
               lt_d      = 1'b0;
               err_d     = 1'b0;
            end
         end

         S_RUN: begin
            // start is ignored while running. A low bit_valid stalls with
            // every piece of state held.
            if (bit_valid) begin
               if (!onehot) begin
                  err_d = 1'b1;
               end else if (!decided_q && gt_bit) begin
                  decided_d = 1'b1;
                  dec_gt_d  = 1'b1;
               end else if (!decided_q && lt_bit) begin
                  decided_d = 1'b1;
                  dec_gt_d  = 1'b0;
               end

               if (cnt_q == LAST_BIT) begin
                  // The verdict includes the decision made on this final bit.
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  gt_d    = decided_d &&  dec_gt_d;
                  lt_d    = decided_d && !dec_gt_d;
                  eq_d    = !decided_d;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         dec_gt_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         gt_q      <= 1'b0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         dec_gt_q  <= dec_gt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         gt_q      <= gt_d;
         eq_q      <= eq_d;
         lt_q      <= lt_d;
         err_q     <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign a_gt_b = gt_q;
   assign a_eq_b = eq_q;
   assign a_lt_b = lt_q;
   assign err    = err_q;

endmodule

// File: tb/tb_serial_mag_compare.sv
// ----------------------------------------------------------------------------
// tb_serial_mag_compare
//
// Directed bench for serial_mag_compare with WIDTH=4. Inputs change 1 ns
// after each rising edge, and outputs are sampled at that same point.
// ----------------------------------------------------------------------------
module tb_serial_mag_compare;

   logic clk = 1'b0;
   logic rst_n, start, bit_valid, gt_bit, eq_bit, lt_bit;
   logic busy, done, a_gt_b, a_eq_b, a_lt_b, err;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t0, t1;

   always #5 clk = ~clk;

   serial_mag_compare #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
      .gt_bit(gt_bit), .eq_bit(eq_bit), .lt_bit(lt_bit),
      .busy(busy), .done(done), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
      .a_lt_b(a_lt_b), .err(err)
   );

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Drives one slice result derived from an A bit and a B bit.
   task automatic send_ab(input logic a, input logic b);
      gt_bit = a & ~b; eq_bit = (a == b); lt_bit = ~a & b;
      bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
   endtask

   task automatic send_raw(input logic [2:0] tri_f);
      {gt_bit, eq_bit, lt_bit} = tri_f;
      bit_valid = 1'b1;
      step();
      bit_valid = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] a, input logic [3:0] b);
      for (int i = 3; i >= 0; i--) send_ab(a[i], b[i]);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; bit_valid = 0; gt_bit = 0; eq_bit = 0; lt_bit = 0;
      step(); step();
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b, err} !== 6'b0)
         $display("FAIL reset_outputs: got %b exp 000000", {busy, done, a_gt_b, a_eq_b, a_lt_b, err});
      else n_pass++;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_gt();
      pulse_start(); t0 = cyc;
      n_checks++; if (busy !== 1'b1) $display("FAIL gt_busy: got %b exp 1", busy); else n_pass++;
      send_word(4'b1010, 4'b1001); t1 = cyc;
      n_checks++; if (done !== 1'b1) $display("FAIL gt_done: got %b exp 1", done); else n_pass++;
      n_checks++; if (t1 - t0 !== 4) $display("FAIL gt_latency: got %0d exp 4", t1 - t0); else n_pass++;
      n_checks++;
      if ({busy, a_gt_b, a_eq_b, a_lt_b, err} !== 5'b01000)
         $display("FAIL gt_verdict: got %b exp 01000", {busy, a_gt_b, a_eq_b, a_lt_b, err});
      else n_pass++;
      step();
      n_checks++;
      if ({done, a_gt_b} !== 2'b01) $display("FAIL gt_hold: got %b exp 01", {done, a_gt_b}); else n_pass++;
   endtask

   task automatic test_eq_lt();
      pulse_start();
      send_word(4'b0110, 4'b0110);
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b} !== 4'b1010)
         $display("FAIL eq_verdict: got %b exp 1010", {done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      step();
      pulse_start();
      send_word(4'b0011, 4'b1000);
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b} !== 4'b1001)
         $display("FAIL lt_verdict: got %b exp 1001", {done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      step();
   endtask

   task automatic test_stall();
      pulse_start(); t0 = cyc;
      send_ab(1'b1, 1'b1);
      step(); step(); step();
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL stall_busy: got %b exp 10", {busy, done}); else n_pass++;
      send_ab(1'b0, 1'b0); send_ab(1'b1, 1'b0); send_ab(1'b0, 1'b1); t1 = cyc;
      n_checks++; if (t1 - t0 !== 7) $display("FAIL stall_latency: got %0d exp 7", t1 - t0); else n_pass++;
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b} !== 4'b1100)
         $display("FAIL stall_verdict: got %b exp 1100", {done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      step();
   endtask

   task automatic test_illegal();
      pulse_start();
      send_raw(3'b110);
      send_ab(1'b1, 1'b1); send_ab(1'b0, 1'b0); send_ab(1'b1, 1'b1);
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b, err} !== 5'b10101)
         $display("FAIL illegal_verdict: got %b exp 10101", {done, a_gt_b, a_eq_b, a_lt_b, err});
      else n_pass++;
      step(); step();
      n_checks++; if (err !== 1'b1) $display("FAIL illegal_err_held: got %b exp 1", err); else n_pass++;
      pulse_start();
      n_checks++;
      if ({busy, err, a_eq_b} !== 3'b100) $display("FAIL illegal_clear: got %b exp 100", {busy, err, a_eq_b}); else n_pass++;
      send_word(4'b0001, 4'b0000);
      n_checks++;
      if ({done, a_gt_b, err} !== 3'b110) $display("FAIL illegal_next: got %b exp 110", {done, a_gt_b, err}); else n_pass++;
      step();
   endtask

   task automatic test_ignored();
      // start together with a bit in DONE: the bit must not be counted.
      start = 1'b1; bit_valid = 1'b1; gt_bit = 1'b1; eq_bit = 1'b0; lt_bit = 1'b0;
      step();
      start = 1'b0; bit_valid = 1'b0;
      send_ab(1'b1, 1'b1);
      start = 1'b1; step(); start = 1'b0;   // mid-run start, no effect
      send_ab(1'b0, 1'b0); send_ab(1'b1, 1'b1);
      n_checks++; if (done !== 1'b0) $display("FAIL ignore_early_done: got %b exp 0", done); else n_pass++;
      send_ab(1'b0, 1'b0);
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b} !== 4'b1010)
         $display("FAIL ignore_verdict: got %b exp 1010", {done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      send_ab(1'b1, 1'b0); send_ab(1'b1, 1'b0);   // bits in DONE ignored
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b} !== 4'b0001)
         $display("FAIL ignore_done_bits: got %b exp 0001", {busy, done, a_gt_b, a_eq_b});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      pulse_start();
      send_word(4'b1100, 4'b0100);
      n_checks++; if ({done, a_gt_b} !== 2'b11) $display("FAIL b2b_first: got %b exp 11", {done, a_gt_b}); else n_pass++;
      pulse_start();   // asserted in the done cycle
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b} !== 5'b10000)
         $display("FAIL b2b_restart: got %b exp 10000", {busy, done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      send_word(4'b0111, 4'b1000);
      n_checks++; if ({done, a_lt_b} !== 2'b11) $display("FAIL b2b_second: got %b exp 11", {done, a_lt_b}); else n_pass++;
      step();
   endtask

   task automatic test_reset_mid();
      pulse_start();
      send_ab(1'b1, 1'b0); send_ab(1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, a_gt_b, a_eq_b, a_lt_b, err} !== 6'b0)
         $display("FAIL midreset_async: got %b exp 000000", {busy, done, a_gt_b, a_eq_b, a_lt_b, err});
      else n_pass++;
      step();
      rst_n = 1'b1;
      bit_valid = 1'b1; gt_bit = 1'b1; eq_bit = 1'b0; lt_bit = 1'b0;
      step(); step(); step();
      bit_valid = 1'b0;
      n_checks++;
      if ({busy, done, a_gt_b} !== 3'b000) $display("FAIL midreset_no_done: got %b exp 000", {busy, done, a_gt_b}); else n_pass++;
      pulse_start();
      send_word(4'b0101, 4'b0110);
      n_checks++;
      if ({done, a_gt_b, a_eq_b, a_lt_b} !== 4'b1001)
         $display("FAIL midreset_fresh: got %b exp 1001", {done, a_gt_b, a_eq_b, a_lt_b});
      else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_gt();
      test_eq_lt();
      test_stall();
      test_illegal();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
